// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register file and its write-port scheduler.
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG  = ADDR_WIDTH'(31);
  localparam logic [ADDR_WIDTH-1:0] LAST_INIT = ADDR_WIDTH'(30);

  typedef enum logic {
    INIT,
    RUN
  } sched_state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the other requester
// after every granted transfer.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_e ptr;

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= REQ_ALU;
    end else if (advance) begin
      ptr <= grant[0] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler: clears registers 0-30 after reset, then shares the
// single register-file write port between the ALU and load writeback paths.
module regfile_write_sched
  import regfile_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AluValid,
  input  logic [ADDR_WIDTH-1:0] AluRW,
  input  logic [DATA_WIDTH-1:0] AluData,
  output logic                  AluReady,
  input  logic                  MemValid,
  input  logic [ADDR_WIDTH-1:0] MemRW,
  input  logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] RW,
  output logic [DATA_WIDTH-1:0] BusW,
  output logic                  RegWr,
  output logic                  InitDone
);

  sched_state_e          state, next_state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [1:0]            req, grant;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] win_rw;
  logic [DATA_WIDTH-1:0] win_data;

  // Requests are masked during the clear sequence; requesters keep Valid up.
  assign req      = (state == RUN) ? {MemValid, AluValid} : 2'b00;
  assign AluReady = grant[0];
  assign MemReady = grant[1];
  assign transfer = |grant;
  assign win_rw   = grant[1] ? MemRW   : AluRW;
  assign win_data = grant[1] ? MemData : AluData;

  rr_arb2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (req),
    .advance (transfer),
    .grant   (grant)
  );

  always_comb begin
    next_state = state;
    if (state == INIT && init_cnt == LAST_INIT) next_state = RUN;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= INIT;
      init_cnt <= '0;
      RW       <= '0;
      BusW     <= '0;
      RegWr    <= 1'b0;
      InitDone <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        INIT: begin
          RegWr    <= 1'b1;
          RW       <= init_cnt;
          BusW     <= '0;
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_INIT) InitDone <= 1'b1;
        end
        RUN: begin
          // A write to the zero register still completes the handshake.
          if (transfer) begin
            RW    <= win_rw;
            BusW  <= win_data;
            RegWr <= (win_rw != ZERO_REG);
          end else begin
            RegWr <= 1'b0;
          end
        end
        default: RegWr <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32 x 64-bit register file (register 31 hard-wired to zero). After reset it clears registers 0-30 to zero, one per cycle. It then shares the single write port (RW, BusW, RegWr) between two writeback requesters, the ALU and the memory-load path, using round-robin arbitration and a valid/ready handshake. It sits between the writeback stage and the register file, and is the only driver of the file's write port.

## Interface
- DATA_WIDTH, 64, width of BusW and requester data
- ADDR_WIDTH, 5, register index width
- ZERO_REG, 31, index that reads as zero; writes to it are never forwarded
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- AluValid  in  1  ALU write request
- AluRW  in  ADDR_WIDTH  ALU destination register
- AluData  in  DATA_WIDTH  ALU write data
- AluReady  out  1  ALU request accepted this cycle
- MemValid  in  1  load write request
- MemRW  in  ADDR_WIDTH  load destination register
- MemData  in  DATA_WIDTH  load write data
- MemReady  out  1  load request accepted this cycle
- RW  out  ADDR_WIDTH  register file write address (registered)
- BusW  out  DATA_WIDTH  register file write data (registered)
- RegWr  out  1  register file write enable (registered)
- InitDone  out  1  clear sequence complete; arbitration active

## Operation
- States: INIT, RUN. Reset forces INIT, InitCnt=0 and RrPtr=ALU. It also forces RW=0, BusW=0, RegWr=0 and InitDone=0.
- INIT:
  - Each cycle, present RegWr=1, RW=InitCnt, BusW=0, then increment InitCnt.
  - When InitCnt=30 is presented, go to RUN and set InitDone=1.
  - AluReady and MemReady stay 0 throughout INIT. Requester Valids are ignored, not lost: requesters hold them.
- RUN:
  - Ready signals are combinational from state, Valids and RrPtr.
  - Only one Valid high: that requester gets Ready=1.
  - Both Valid high: the requester RrPtr points to wins. The loser sees Ready=0.
  - Transfer occurs when Valid and Ready are both high at a rising edge. On transfer, RrPtr is set to the other requester.
  - With no contention, RrPtr still toggles on each transfer.
- Registered output: a transfer at edge E drives RW/BusW from the winner at E, held until the next edge.
  - RegWr=1 unless the destination equals ZERO_REG. In that case RegWr=0, but the transfer still completes: Ready=1, pointer updates.
  - With no transfer at edge E: RegWr=0; RW and BusW hold their previous values.
- Requester rule: once Valid is high, RW, Data and Valid hold until accepted. The scheduler does not check this.
- Reset asserted mid-RUN or mid-INIT:
  - Any in-flight output is dropped at that edge (RegWr=0).
  - The clear sequence restarts from register 0.
  - Accepted-but-unpresented writes do not exist, because output is single-stage.

## Timing
- Clear sequence: 31 cycles. Counting from the first edge with Reset low as E1, edge Ek presents RW=k-1 for k=1..31.
- InitDone rises at E31. The first possible transfer is at E32.
- Request-to-write latency: transfer at edge E gives RegWr/RW/BusW valid from E to E+1 (one cycle). The register file commits on the following falling edge.
- Throughput: one write per cycle. Under continuous contention, grants alternate ALU, MEM, ALU, ...
- Read-after-write: new data is visible on BusA/BusB after the register file commit, two edges after the transfer. Forwarding is not this block's job.

## Structure
- Shared package `regfile_pkg`:
  - DATA_WIDTH, ADDR_WIDTH, ZERO_REG and NUM_REGS=32 constants.
  - Scheduler state enum (INIT, RUN).
  - Requester id enum (REQ_ALU, REQ_MEM).
- One sub-module, `rr_arb2`: 2-input round-robin arbiter with a pointer register. Inputs req[1:0] and advance; output grant[1:0].
- The top level holds the FSM, InitCnt and the output registers.

## Test plan
- Reset, then release: for edges E1..E31, RegWr=1, RW=0..30, BusW=0. InitDone=1 from E31. AluReady=MemReady=0 throughout, even with both Valids held high.
- After init, AluValid only, AluRW=10, AluData=0x1010: AluReady=1. The next cycle shows RegWr=1, RW=10, BusW=0x1010. Reading RA=10 afterwards returns 0x1010.
- Both Valid continuously, ALU RW=11 / 0x103000, MEM RW=13 / 0xABCD, each requester dropping Valid after its own accept:
  - ALU is accepted first (pointer reset value); MEM is accepted on the next cycle.
  - Outputs are RW=11 then RW=13 on consecutive cycles.
- MemValid with MemRW=31, MemData=0x12345678: MemReady=1, the following cycle RegWr=0, and register 31 still reads 0.
- Reset asserted mid-RUN while a transfer (AluRW=5) is accepted at the same edge: RegWr=0 after that edge, InitDone=0, and the clear sequence restarts at RW=0. Register 5 reads 0 after InitDone.
- Idle RUN with no Valids for 10 cycles: RegWr=0, and RW/BusW hold the last written values.
